// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the branch target buffer.
// Counter widths are handled at their maximum width here. Each user slices the result down
// to its own CTR_BITS.
package branch_predictor_pkg;

    localparam int unsigned CTR_BITS_MAX = 4;

    typedef logic [CTR_BITS_MAX-1:0] ctr_t;

    // Weakly-taken: MSB set, remaining bits clear.
    function automatic ctr_t ctr_weak_t(input int unsigned bits);
        return ctr_t'(5'd1 << (bits - 1));
    endfunction

    // Weakly-not-taken: MSB clear, remaining bits set.
    function automatic ctr_t ctr_weak_nt(input int unsigned bits);
        return ctr_t'((5'd1 << (bits - 1)) - 5'd1);
    endfunction

    // Saturating up/down step of a bits-wide counter.
    function automatic ctr_t next_ctr(input ctr_t ctr, input logic taken,
                                      input int unsigned bits);
        ctr_t max_v;
        max_v = ctr_t'((5'd1 << bits) - 5'd1);
        if (taken) begin
            return (ctr == max_v) ? ctr : ctr + 4'd1;
        end
        return (ctr == '0) ? ctr : ctr - 4'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute update and statistics signals of the branch predictor.
interface branch_predictor_if #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
);
    logic [PC_W-1:0]  lk_pc;
    logic             lk_hit;
    logic             lk_taken;
    logic [PC_W-1:0]  lk_target;
    logic             up_valid;
    logic [PC_W-1:0]  up_pc;
    logic             up_taken;
    logic [PC_W-1:0]  up_target;
    logic             up_pred_taken;
    logic [PC_W-1:0]  up_pred_target;
    logic             stall;
    logic             invalidate;
    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;

    // Pipeline side: drives PCs and resolutions, consumes predictions.
    modport master (
        output lk_pc, up_valid, up_pc, up_taken, up_target, up_pred_taken, up_pred_target,
               stall, invalidate,
        input  lk_hit, lk_taken, lk_target, mispredict, redirect_pc, br_count, mp_count
    );

    // Predictor side.
    modport slave (
        input  lk_pc, up_valid, up_pc, up_taken, up_target, up_pred_taken, up_pred_target,
               stall, invalidate,
        output lk_hit, lk_taken, lk_target, mispredict, redirect_pc, br_count, mp_count
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Combinational next state of one CTR_BITS-wide saturating direction counter.
// It is used once on the update path. It is not replicated per table entry.
module branch_predictor_sat_counter
    import branch_predictor_pkg::*;
#(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                taken,
    output logic [CTR_BITS-1:0] ctr_next
);

    ctr_t nxt_full;
    logic unused_nxt;

    // Step at full width, then keep only the live bits.
    always_comb begin
        nxt_full   = next_ctr(ctr_t'(ctr), taken, CTR_BITS);
        ctr_next   = nxt_full[CTR_BITS-1:0];
        unused_nxt = ^nxt_full;
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating-counter direction prediction.
// Lookup is zero latency from registered state. Update is driven from EX, and this block
// also makes the mispredict/redirect decision and keeps branch statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    branch_predictor_if.slave bp
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    localparam ctr_t WEAK_T_FULL  = ctr_weak_t(CTR_BITS);
    localparam ctr_t WEAK_NT_FULL = ctr_weak_nt(CTR_BITS);
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = WEAK_T_FULL[CTR_BITS-1:0];
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = WEAK_NT_FULL[CTR_BITS-1:0];

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [PC_W-1:0]     target;
        logic [CTR_BITS-1:0] ctr;
    } btb_entry_t;

    btb_entry_t table_q [ENTRIES];

    logic [CNT_W-1:0] br_count_q;
    logic [CNT_W-1:0] mp_count_q;

    logic [IDX_W-1:0]    lk_idx;
    logic [TAG_W-1:0]    lk_tag;
    btb_entry_t          lk_entry;
    logic [IDX_W-1:0]    up_idx;
    logic [TAG_W-1:0]    up_tag;
    btb_entry_t          up_entry;
    logic                up_fire;
    logic                up_match;
    logic                do_write;
    btb_entry_t          new_entry;
    logic [CTR_BITS-1:0] up_ctr_next;
    logic                mispredict;
    logic                unused_bits;

    // Fetch-side lookup. There is no bypass, so a same-cycle update is seen one cycle later.
    always_comb begin
        lk_idx       = bp.lk_pc[IDX_W+1:2];
        lk_tag       = bp.lk_pc[PC_W-1:IDX_W+2];
        lk_entry     = table_q[lk_idx];
        bp.lk_hit    = lk_entry.valid && (lk_entry.tag == lk_tag);
        bp.lk_taken  = bp.lk_hit && lk_entry.ctr[CTR_BITS-1];
        bp.lk_target = bp.lk_taken ? lk_entry.target : bp.lk_pc + PC_W'(4);
    end

    branch_predictor_sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) u_sat_counter (
        .ctr      (up_entry.ctr),
        .taken    (bp.up_taken),
        .ctr_next (up_ctr_next)
    );

    // Update path: decide whether the indexed entry is trained, allocated or left alone.
    always_comb begin
        up_fire   = bp.up_valid && !bp.stall;
        up_idx    = bp.up_pc[IDX_W+1:2];
        up_tag    = bp.up_pc[PC_W-1:IDX_W+2];
        up_entry  = table_q[up_idx];
        up_match  = up_entry.valid && (up_entry.tag == up_tag);
        new_entry = up_entry;
        if (up_match) begin
            new_entry.ctr = up_ctr_next;
            if (bp.up_taken) begin
                new_entry.target = bp.up_target;
            end
        end else begin
            new_entry.valid  = 1'b1;
            new_entry.tag    = up_tag;
            new_entry.target = bp.up_target;
            new_entry.ctr    = CTR_WEAK_T;
        end
        // Invalidate wins over any same-cycle write.
        do_write = up_fire && !bp.invalidate && (up_match || bp.up_taken);
    end

    // Resolution check and the redirect target for the hazard unit.
    always_comb begin
        mispredict     = up_fire && ((bp.up_taken != bp.up_pred_taken) ||
                         (bp.up_taken && (bp.up_target != bp.up_pred_target)));
        bp.mispredict  = mispredict;
        bp.redirect_pc = (mispredict && bp.up_taken) ? bp.up_target : bp.up_pc + PC_W'(4);
        bp.br_count    = br_count_q;
        bp.mp_count    = mp_count_q;
        unused_bits    = ^{bp.lk_pc[1:0], bp.up_pc[1:0], lk_entry.ctr};
    end

    // BTB storage. An asynchronous reset drops any in-flight update entirely.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i].valid  <= 1'b0;
                table_q[i].tag    <= '0;
                table_q[i].target <= '0;
                table_q[i].ctr    <= CTR_WEAK_NT;
            end
        end else if (bp.invalidate) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i].valid <= 1'b0;
            end
        end else if (do_write) begin
            table_q[up_idx] <= new_entry;
        end
    end

    // Branch statistics. These still count updates that coincide with invalidate.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            br_count_q <= '0;
            mp_count_q <= '0;
        end else begin
            if (up_fire) begin
                br_count_q <= br_count_q + CNT_W'(1);
            end
            if (mispredict) begin
                mp_count_q <= mp_count_q + CNT_W'(1);
            end
        end
    end

endmodule
